// File: rtl/inst_itf_demux_n.sv
// rtl/inst_itf_demux_n.sv - N-target instruction-fetch demux with decode-miss and timeout error completion
module inst_itf_demux_n #(
    parameter int                        N_TGT    = 2,
    parameter int                        AW       = 32,
    parameter int                        DW       = 32,
    parameter logic [N_TGT-1:0][AW-1:0]  TGT_BASE = {32'h0001_0000, 32'h0000_0000},
    parameter logic [N_TGT-1:0][AW-1:0]  TGT_END  = {32'h0001_ffff, 32'h0000_0fff},
    parameter int                        TIMEOUT  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                core_req_i,
    input  logic [AW-1:0]       core_addr_i,
    output logic                core_ack_o,
    output logic [DW-1:0]       core_data_o,
    output logic                core_error_o,
    output logic [N_TGT-1:0]    tgt_req_o,
    output logic [AW-1:0]       tgt_addr_o,
    input  logic [N_TGT-1:0]    tgt_ack_i,
    input  logic [N_TGT*DW-1:0] tgt_data_i,
    input  logic [N_TGT-1:0]    tgt_error_i,
    output logic                busy_o,
    output logic [7:0]          err_cnt_o
);

    localparam int SW = (N_TGT > 1) ? $clog2(N_TGT) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t        state;
    logic [SW-1:0] sel;
    logic [CW-1:0] cnt;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          hit;
    logic [SW-1:0] hit_idx;
    logic          sel_ack;

    // Offset-from-base form keeps the window test free of constant compares when a base is 0.
    // Descending loop so the lowest matching index is the last assignment and wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = N_TGT - 1; k >= 0; k--) begin
            if ((core_addr_i - TGT_BASE[k]) <= (TGT_END[k] - TGT_BASE[k])) begin
                hit     = 1'b1;
                hit_idx = SW'(k);
            end
        end
    end

    assign sel_ack = tgt_ack_i[sel];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            err_cnt_o  <= 8'd0;
            tgt_addr_o <= '0;
            sel        <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (core_req_i) begin
                        tgt_addr_o <= core_addr_i;
                        if (hit) begin
                            sel   <= hit_idx;
                            state <= REQ;
                        end else begin
                            rsp_data <= '0;
                            rsp_err  <= 1'b1;
                            if (err_cnt_o != 8'hff) err_cnt_o <= err_cnt_o + 8'd1;
                            state    <= RSP;
                        end
                    end
                end
                REQ: begin
                    cnt <= cnt + 1'b1;
                    if (sel_ack) begin
                        rsp_data <= tgt_data_i[int'(sel)*DW +: DW];
                        rsp_err  <= tgt_error_i[sel];
                        state    <= RSP;
                    end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        if (err_cnt_o != 8'hff) err_cnt_o <= err_cnt_o + 8'd1;
                        state    <= RSP;
                    end
                end
                RSP: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        tgt_req_o = '0;
        if (state == REQ) tgt_req_o[sel] = 1'b1;
    end

    assign core_ack_o   = (state == RSP);
    assign core_data_o  = (state == RSP) ? rsp_data : '0;
    assign core_error_o = (state == RSP) && rsp_err;
    assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_inst_itf_demux_n.sv
// tb/tb_inst_itf_demux_n.sv - directed self-checking bench for inst_itf_demux_n
module tb_inst_itf_demux_n;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req;
    logic [31:0] core_addr;
    logic        core_ack;
    logic [31:0] core_data;
    logic        core_error;
    logic [1:0]  tgt_req;
    logic [31:0] tgt_addr;
    logic [1:0]  tgt_ack;
    logic [63:0] tgt_data;
    logic [1:0]  tgt_error;
    logic        busy;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    inst_itf_demux_n dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .core_req_i  (core_req),
        .core_addr_i (core_addr),
        .core_ack_o  (core_ack),
        .core_data_o (core_data),
        .core_error_o(core_error),
        .tgt_req_o   (tgt_req),
        .tgt_addr_o  (tgt_addr),
        .tgt_ack_i   (tgt_ack),
        .tgt_data_i  (tgt_data),
        .tgt_error_i (tgt_error),
        .busy_o      (busy),
        .err_cnt_o   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; core_req = 1'b0; core_addr = '0;
        tgt_ack = '0; tgt_data = '0; tgt_error = '0;
        step(); step();
        checks++;
        if ({core_ack, core_data, core_error, tgt_req, tgt_addr, busy, err_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b data=%h err=%b req=%b addr=%h busy=%b cnt=%0d, required all 0",
                     core_ack, core_data, core_error, tgt_req, tgt_addr, busy, err_cnt);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_hit_t0();
        core_req = 1'b1; core_addr = 32'h0000_0100;
        tgt_data = {32'h5555_5555, 32'hDEAD_BEEF};
        step();
        core_req = 1'b0;
        checks++;
        if (tgt_req !== 2'b01 || core_ack !== 1'b0 || busy !== 1'b1 || tgt_addr !== 32'h100) begin
            errors++;
            $display("FAIL t1_req_cycle1: req=%b ack=%b busy=%b addr=%h, required 01 0 1 00000100", tgt_req, core_ack, busy, tgt_addr);
        end
        step();
        checks++;
        if (tgt_req !== 2'b01 || core_ack !== 1'b0) begin
            errors++;
            $display("FAIL t1_req_cycle2: req=%b ack=%b, required 01 0", tgt_req, core_ack);
        end
        tgt_ack = 2'b01;
        step();
        tgt_ack = 2'b00;
        checks++;
        if (core_ack !== 1'b1 || core_data !== 32'hDEAD_BEEF || core_error !== 1'b0 || tgt_req !== 2'b00) begin
            errors++;
            $display("FAIL t1_rsp: ack=%b data=%h err=%b req=%b, required 1 deadbeef 0 00", core_ack, core_data, core_error, tgt_req);
        end
        step();
        checks++;
        if (core_ack !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t1_idle: ack=%b busy=%b, required 0 0", core_ack, busy);
        end
    endtask

    task automatic test_miss();
        core_req = 1'b1; core_addr = 32'h0002_0000;
        step();
        core_req = 1'b0;
        checks++;
        if (core_ack !== 1'b1 || core_error !== 1'b1 || core_data !== 32'h0 || tgt_req !== 2'b00 || err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL t2_miss: ack=%b err=%b data=%h req=%b cnt=%0d, required 1 1 0 00 1",
                     core_ack, core_error, core_data, tgt_req, err_cnt);
        end
        step();
    endtask

    task automatic test_timeout();
        int bad = 0;
        core_req = 1'b1; core_addr = 32'h0001_0004;
        step();
        core_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (tgt_req !== 2'b10 || core_ack !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL t3_req_held: %0d bad cycles of 16, required 0", bad);
        end
        checks++;
        if (core_ack !== 1'b1 || core_error !== 1'b1 || core_data !== 32'h0 || err_cnt !== 8'd2 || tgt_req !== 2'b00) begin
            errors++;
            $display("FAIL t3_timeout_rsp: ack=%b err=%b data=%h cnt=%0d req=%b, required 1 1 0 2 00",
                     core_ack, core_error, core_data, err_cnt, tgt_req);
        end
        step();
    endtask

    task automatic test_race();
        core_req = 1'b1; core_addr = 32'h0001_0004;
        tgt_data = {32'h1234_5678, 32'hBAD0_BAD0};
        step();
        core_req = 1'b0;
        for (int i = 0; i < 15; i++) step();
        checks++;
        if (tgt_req !== 2'b10 || core_ack !== 1'b0) begin
            errors++;
            $display("FAIL t4_last_req_cycle: req=%b ack=%b, required 10 0", tgt_req, core_ack);
        end
        tgt_ack = 2'b10;
        step();
        tgt_ack = 2'b00;
        checks++;
        if (core_ack !== 1'b1 || core_data !== 32'h1234_5678 || core_error !== 1'b0 || err_cnt !== 8'd2) begin
            errors++;
            $display("FAIL t4_race_rsp: ack=%b data=%h err=%b cnt=%0d, required 1 12345678 0 2",
                     core_ack, core_data, core_error, err_cnt);
        end
        step();
    endtask

    task automatic test_back_to_back();
        core_req = 1'b1; core_addr = 32'h0000_0100;
        tgt_data = {32'h0, 32'hAAAA_0001};
        step();
        tgt_ack = 2'b01;
        step();
        tgt_ack = 2'b00;
        checks++;
        if (core_ack !== 1'b1 || core_data !== 32'hAAAA_0001 || core_error !== 1'b0) begin
            errors++;
            $display("FAIL t5_first_rsp: ack=%b data=%h err=%b, required 1 aaaa0001 0", core_ack, core_data, core_error);
        end
        core_addr = 32'h0001_0000;
        step();
        checks++;
        if (core_ack !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t5_gap_idle: ack=%b busy=%b, required 0 0", core_ack, busy);
        end
        step();
        core_req = 1'b0;
        checks++;
        if (tgt_req !== 2'b10 || tgt_addr !== 32'h0001_0000) begin
            errors++;
            $display("FAIL t5_second_req: req=%b addr=%h, required 10 00010000", tgt_req, tgt_addr);
        end
        tgt_ack = 2'b01; tgt_data = {32'hBBBB_0002, 32'hFFFF_FFFF};
        step();
        checks++;
        if (core_ack !== 1'b0 || tgt_req !== 2'b10) begin
            errors++;
            $display("FAIL t5_spurious_ack: ack=%b req=%b, required 0 10", core_ack, tgt_req);
        end
        tgt_ack = 2'b10; tgt_error = 2'b10;
        step();
        tgt_ack = 2'b00; tgt_error = 2'b00;
        checks++;
        if (core_ack !== 1'b1 || core_data !== 32'hBBBB_0002 || core_error !== 1'b1 || err_cnt !== 8'd2) begin
            errors++;
            $display("FAIL t5_second_rsp: ack=%b data=%h err=%b cnt=%0d, required 1 bbbb0002 1 2",
                     core_ack, core_data, core_error, err_cnt);
        end
        step();
    endtask

    task automatic test_reset_and_saturate();
        int acks = 0;
        int stray = 0;
        core_req = 1'b1; core_addr = 32'h0000_0100;
        step();
        core_req = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({core_ack, core_data, core_error, tgt_req, tgt_addr, busy, err_cnt} !== '0) begin
            errors++;
            $display("FAIL t6_reset_mid: ack=%b data=%h err=%b req=%b addr=%h busy=%b cnt=%0d, required all 0",
                     core_ack, core_data, core_error, tgt_req, tgt_addr, busy, err_cnt);
        end
        tgt_ack = 2'b01;
        for (int i = 0; i < 4; i++) begin
            if (core_ack !== 1'b0 || tgt_req !== 2'b00) stray++;
            step();
        end
        tgt_ack = 2'b00;
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL t6_abandoned: %0d cycles with ack or req, required 0", stray);
        end
        core_addr = 32'h0002_0000;
        for (int i = 1; i <= 300; i++) begin
            core_req = 1'b1;
            step();
            core_req = 1'b0;
            if (core_ack === 1'b1 && core_error === 1'b1) acks++;
            if (i == 254) begin
                checks++;
                if (err_cnt !== 8'd254) begin
                    errors++;
                    $display("FAIL t6_cnt_254: cnt=%0d, required 254", err_cnt);
                end
            end
            step();
        end
        checks++;
        if (acks != 300) begin
            errors++;
            $display("FAIL t6_miss_acks: %0d, required 300", acks);
        end
        checks++;
        if (err_cnt !== 8'd255) begin
            errors++;
            $display("FAIL t6_saturate: cnt=%0d, required 255", err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_hit_t0();
        test_miss();
        test_timeout();
        test_race();
        test_back_to_back();
        test_reset_and_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
